// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply, restoring divide.
// Define MULDIV_ACCUM_EN to enable the MADD/MSUBU accumulate opcodes.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MUL_RUN = 3'd1;
    localparam logic [2:0] S_DIV_RUN = 3'd2;
    localparam logic [2:0] S_FIX     = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [3:0] OP_MUL   = 4'b0000;
    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_MADD  = 4'b0011;
`ifdef MULDIV_ACCUM_EN
    localparam logic [3:0] OP_MSUBU = 4'b0100;
`endif
    localparam logic [3:0] OP_DIV   = 4'b0101;
    localparam logic [3:0] OP_DIVU  = 4'b0110;
    localparam logic [3:0] OP_MFHI  = 4'b0111;
    localparam logic [3:0] OP_MFLO  = 4'b1000;
    localparam logic [3:0] OP_MTHI  = 4'b1001;
    localparam logic [3:0] OP_MTLO  = 4'b1010;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MULDIV_ACCUM_EN
        return op inside {OP_MUL, OP_MULT, OP_MULTU, OP_MADD, OP_MSUBU};
`else
        return op inside {OP_MUL, OP_MULT, OP_MULTU};
`endif
    endfunction

    logic [3:0]         op_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               neg_a;
    logic               neg_b;

    logic               accept;
    logic               sign_op;
    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept   = start && (state == S_IDLE || state == S_DONE);
    assign busy     = (state == S_MUL_RUN) || (state == S_DIV_RUN) || (state == S_FIX);
    assign sign_op  = operation inside {OP_MUL, OP_MULT, OP_MADD, OP_DIV};
    assign rs_neg   = sign_op & rs[WIDTH-1];
    assign rt_neg   = sign_op & rt[WIDTH-1];
    assign rs_mag   = rs_neg ? -rs : rs;
    assign rt_mag   = rt_neg ? -rt : rt;

    // Divide keeps {remainder, dividend/quotient} in acc; dividend bits shift out the top of the low half.
    assign div_diff = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mplier};
    assign prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    assign quo_fix  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            div_zero <= 1'b0;
            out      <= '0;
            hi       <= '0;
            lo       <= '0;
            op_q     <= '0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_MUL_RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_ITER) state <= S_FIX;
                end
                S_DIV_RUN: begin
                    if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    else                  acc <= {acc[2*WIDTH-2:0], 1'b0};
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_ITER) state <= S_FIX;
                end
                S_FIX: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    case (op_q)
                        OP_MUL:           out      <= prod_fix[WIDTH-1:0];
                        OP_MULT, OP_MULTU: {hi, lo} <= prod_fix;
`ifdef MULDIV_ACCUM_EN
                        OP_MADD:          {hi, lo} <= {hi, lo} + prod_fix;
                        OP_MSUBU:         {hi, lo} <= {hi, lo} - prod_fix;
`endif
                        OP_DIV, OP_DIVU: begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end
                        default: ;
                    endcase
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // Only reachable from IDLE/DONE, so it never collides with the RUN/FIX branches above.
            if (accept) begin
                op_q  <= operation;
                neg_a <= rs_neg;
                neg_b <= rt_neg;
                cnt   <= '0;
                if (is_mul_op(operation)) begin
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, rs_mag};
                    mplier <= rt_mag;
                    state  <= S_MUL_RUN;
                end else if (operation == OP_DIV || operation == OP_DIVU) begin
                    if (rt == '0) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        div_zero <= 1'b1;
                    end else begin
                        acc    <= {{WIDTH{1'b0}}, rs_mag};
                        mplier <= rt_mag;
                        state  <= S_DIV_RUN;
                    end
                end else begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    case (operation)
                        OP_MFHI: out <= hi;
                        OP_MFLO: out <= lo;
                        OP_MTHI: hi  <= rs;
                        OP_MTLO: lo  <= rs;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a behavioural HI/LO model pushes expected out values,
// which are popped when the unit pulses done. Cycle 1 is the clock period right after the accepting edge.
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [3:0] OP_MUL   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_MADD  = 4'd3;
    localparam logic [3:0] OP_MSUBU = 4'd4;
    localparam logic [3:0] OP_DIV   = 4'd5;
    localparam logic [3:0] OP_DIVU  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DONE = 3'd4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   operation;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] out;
    logic [2:0]   state;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .operation (operation),
        .rs        (rs),
        .rt        (rt),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .out       (out),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] op, input logic [W-1:0] b);
        if (op inside {OP_MUL, OP_MULT, OP_MULTU}) return W + 2;
`ifdef MULDIV_ACCUM_EN
        if (op inside {OP_MADD, OP_MSUBU}) return W + 2;
`endif
        if ((op == OP_DIV || op == OP_DIVU) && b != 0) return W + 2;
        return 1;
    endfunction

    // Behavioural reference built on the language's own arithmetic operators.
    task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa;
        longint       sb;
        longint       q;
        longint       r;
        logic [63:0]  p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MUL: begin
                p = sa * sb;
                exp_q.push_back(p[W-1:0]);
            end
            OP_MULT:  {m_hi, m_lo} = sa * sb;
            OP_MULTU: {m_hi, m_lo} = {32'b0, a} * {32'b0, b};
`ifdef MULDIV_ACCUM_EN
            OP_MADD: begin
                p = sa * sb;
                {m_hi, m_lo} = {m_hi, m_lo} + p;
            end
            OP_MSUBU: {m_hi, m_lo} = {m_hi, m_lo} - ({32'b0, a} * {32'b0, b});
`endif
            OP_DIV: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                p = q;
                m_lo = p[W-1:0];
                p = r;
                m_hi = p[W-1:0];
            end
            OP_DIVU: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            OP_MFHI: exp_q.push_back(m_hi);
            OP_MFLO: exp_q.push_back(m_lo);
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // poke: cycle at which a MULT 9*9 start is driven while busy; rst_at: cycle at which reset aborts.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke, input int rst_at);
        int           lat;
        int           c;
        bit           seen;
        bit           late_done;
        logic         dz;
        logic [W-1:0] e;
        lat = exp_lat(op, b);
        dz  = (op == OP_DIV || op == OP_DIVU) && b == 0;
        if (rst_at == 0) model_op(op, a, b);

        @(negedge clk);
        start = 1'b1; operation = op; rs = a; rt = b;
        @(posedge clk); #1;
        start = 1'b0; rs = $urandom; rt = $urandom;
        c = 1;
        seen = 1'b0;
        if (lat > 1) check_eq($sformatf("busy_c1_op%0d", op), busy, 1'b1);

        while (c <= lat + 5) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (c == lat - 1 && lat > 2) check_eq($sformatf("busy_fix_op%0d", op), busy, 1'b1);
            if (c == rst_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                m_hi = '0;
                m_lo = '0;
                check_eq("abort_busy", busy, 1'b0);
                check_eq("abort_state", state, S_IDLE);
                check_eq("abort_done", done, 1'b0);
                late_done = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk); #1;
                    if (done) late_done = 1'b1;
                end
                check_eq("abort_no_done", late_done, 1'b0);
                return;
            end
            if (c == poke) begin
                start = 1'b1; operation = OP_MULT; rs = 9; rt = 9;
            end
            @(posedge clk); #1;
            start = 1'b0;
            c++;
        end

        check_eq($sformatf("done_seen_op%0d", op), seen, 1'b1);
        check_eq($sformatf("latency_op%0d", op), c, lat);
        check_eq($sformatf("div_zero_op%0d", op), div_zero, dz);
        check_eq($sformatf("busy_done_op%0d", op), busy, 1'b0);
        check_eq($sformatf("state_done_op%0d", op), state, S_DONE);
        if (op inside {OP_MUL, OP_MFHI, OP_MFLO} && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq($sformatf("out_op%0d", op), out, e);
        end
        @(posedge clk); #1;
        check_eq($sformatf("done_pulse_op%0d", op), {done, div_zero}, 2'b00);
    endtask

    task automatic read_hilo();
        run_op(OP_MFHI, '0, '0, 0, 0);
        run_op(OP_MFLO, '0, '0, 0, 0);
    endtask

    initial begin
        logic [3:0]   pool [9];
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        pool = '{OP_MUL, OP_MULT, OP_MULTU, OP_MADD, OP_MSUBU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
        m_hi = '0;
        m_lo = '0;

        // Reset held with a competing MTHI start: the start must be overridden.
        reset = 1'b1; start = 1'b1; operation = OP_MTHI; rs = 32'hDEADBEEF; rt = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_div_zero", div_zero, 1'b0);
        check_eq("rst_out", out, '0);
        check_eq("rst_state", state, S_IDLE);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        read_hilo();

        run_op(OP_MULT, 32'd7, 32'hFFFFFFFD, 0, 0);
        read_hilo();

        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, 0);
        read_hilo();
        run_op(OP_DIVU, 32'hFFFFFFF9, 32'd2, 0, 0);
        read_hilo();

        run_op(OP_MTHI, 32'h12345678, '0, 0, 0);
        run_op(OP_MTLO, 32'h12345678, '0, 0, 0);
        run_op(OP_DIV, 32'd5, 32'd0, 0, 0);
        read_hilo();

        run_op(OP_MTHI, 32'd0, '0, 0, 0);
        run_op(OP_MTLO, 32'd5, '0, 0, 0);
        run_op(OP_MADD, 32'd2, 32'd3, 0, 0);
        run_op(OP_MFLO, '0, '0, 0, 0);

        run_op(OP_MUL, 32'hFFFFFFFF, 32'd3, 0, 0);
        read_hilo();
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        read_hilo();
        run_op(OP_MSUBU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        read_hilo();
        run_op(4'hF, 32'h1, 32'h2, 0, 0);
        run_op(4'hB, 32'h3, 32'h4, 0, 0);
        read_hilo();

        // Start while busy is ignored; reset mid-run aborts and clears HI/LO.
        run_op(OP_MULT, 32'd3, 32'd4, 5, 0);
        read_hilo();
        run_op(OP_MULT, 32'd5, 32'd6, 0, 10);
        read_hilo();

        for (int i = 0; i < 20; i++) begin
            op = pool[$urandom_range(0, 8)];
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 100));
                default: b = $urandom;
            endcase
            run_op(op, a, b, 0, 0);
            read_hilo();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO word width; legal even values 8..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request strobe; sampled each rising edge.
REQ-005 operation  input  4  opcode, sampled with start.
REQ-006 rs  input  WIDTH  first operand, sampled with start.
REQ-007 rt  input  WIDTH  second operand, sampled with start.
REQ-008 busy  output  1  high while an iterative operation is in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 div_zero  output  1  one-cycle pulse, coincident with done, for division by zero.
REQ-011 out  output  WIDTH  registered result for MUL/MFHI/MFLO.

Function
REQ-012 Opcodes: 0000 MUL, 0001 MULT, 0010 MULTU, 0011 MADD, 0100 MSUBU, 0101 DIV, 0110 DIVU, 0111 MFHI, 1000 MFLO, 1001 MTHI, 1010 MTLO; all others: NOP, done pulse next cycle, no state change.
REQ-013 Request accepted on an edge with start=1 and busy=0; start while busy is ignored, with no effect on the running operation.
REQ-014 FSM states IDLE, MUL_RUN, DIV_RUN, FIX, DONE; IDLE->MUL_RUN/DIV_RUN on accept of a multiply or divide op; RUN->FIX after WIDTH iteration cycles; FIX->DONE->IDLE.
REQ-015 busy=1 in MUL_RUN, DIV_RUN and FIX; busy=0 in IDLE and DONE; a new start is accepted in DONE.
REQ-016 Multiply and divide latency: done asserted exactly WIDTH+2 cycles after the accepting edge; HI/LO/out are updated on the edge that enters DONE.
REQ-017 MFHI, MFLO, MTHI, MTLO: single-cycle, with no busy; the register is updated on the accepting edge and done pulses in the following cycle.
REQ-018 Multiply is an iterative shift-add over operand magnitudes, one bit per cycle, with a 2*WIDTH-bit product; signed ops negate the product in FIX when the operand signs differ.
REQ-019 MULT/MULTU: {HI,LO} <= product. MUL: out <= product[WIDTH-1:0], HI/LO unchanged.
REQ-020 MADD: {HI,LO} <= {HI,LO} + signed product. MSUBU: {HI,LO} <= {HI,LO} - unsigned product; both wrap modulo 2^(2*WIDTH).
REQ-021 Divide is restoring, one quotient bit per cycle; LO <= quotient truncated toward zero, HI <= remainder with the sign of the dividend.
REQ-022 DIV of the most-negative value by -1: LO <= most-negative value, HI <= 0, no flag.
REQ-023 rt=0 with DIV/DIVU: no iteration; done and div_zero pulse in the cycle after accept, HI/LO unchanged.
REQ-024 MFHI: out <= HI; MFLO: out <= LO; MTHI: HI <= rs; MTLO: LO <= rs.
REQ-025 Operands are latched at accept; rs/rt changes during RUN have no effect.

Reset
REQ-026 reset=1 forces IDLE, busy=0, done=0, div_zero=0, out=0, HI=0, LO=0 on the next edge, overriding start.
REQ-027 Reset during RUN/FIX aborts the operation; no done pulse is produced for it.

Configuration
REQ-028 Macro MULDIV_ACCUM_EN: when defined, MADD and MSUBU behave per REQ-020.
REQ-029 When MULDIV_ACCUM_EN is undefined, opcodes 0011 and 0100 decode as NOP (REQ-012) and no accumulate adder is synthesised.

Verification
REQ-030 WIDTH=32, MULT rs=7 rt=0xFFFFFFFD -> done at cycle 34 after accept, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-031 DIV rs=0xFFFFFFF9 (-7) rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
REQ-032 DIV rs=5 rt=0, with HI=LO=0x12345678 -> done and div_zero both high one cycle after accept, HI/LO still 0x12345678.
REQ-033 With MULDIV_ACCUM_EN: MTHI 0, MTLO 5, MADD 2*3, MFLO -> out=0x0000000B; without the macro the same sequence gives out=0x00000005.
REQ-034 MULT 3*4 started, start+MULT 9*9 at cycle 5 -> ignored, LO=12; reset at cycle 10 of a second MULT -> busy=0, no done, HI=LO=0.
